soi_injector: RTL

SOI_INJECTOR -- requirements
Module: soi_injector

---
 rtl/soi_injector.sv | 139 +++++++++++++
 1 files changed

// File: rtl/soi_injector.sv
// soi_injector: command-driven force/release/pulse/read injector for signal-of-interest channels.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o    command handshake; cmd_op_i/cmd_idx_i/cmd_data_i latched on accept
//                              (op: 00 FORCE, 01 RELEASE, 10 PULSE, 11 READ)
//   soi_in_i/soi_out_o         observed signals in, possibly forced signals out (channel i at [i*SOI_W +: SOI_W])
//   force_mask_o               per-channel force-enable flags
//   rsp_valid_o/rsp_ready_i    response handshake; rsp_data_o is the READ result, rsp_err_o flags a bad index
module soi_injector #(
  parameter int NUM_SOI   = 8,
  parameter int SOI_W     = 8,
  parameter int PULSE_CYC = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [1:0]                 cmd_op_i,
  input  logic [3:0]                 cmd_idx_i,
  input  logic [SOI_W-1:0]           cmd_data_i,
  input  logic [NUM_SOI*SOI_W-1:0]   soi_in_i,
  output logic [NUM_SOI*SOI_W-1:0]   soi_out_o,
  output logic [NUM_SOI-1:0]         force_mask_o,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [SOI_W-1:0]           rsp_data_o,
  output logic                       rsp_err_o
);
  localparam int CW = $clog2(PULSE_CYC + 1);
  localparam logic [4:0] NUM_W = 5'(NUM_SOI);
  typedef enum logic [1:0] {IDLE, EXEC, PULSE, RESP} state_t;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [3:0] idx_q, idx_d;
  logic [SOI_W-1:0] data_q, data_d;
  logic [NUM_SOI-1:0] mask_q, mask_d, hit;
  logic [SOI_W-1:0] val_q [NUM_SOI];
  logic [SOI_W-1:0] val_d [NUM_SOI];
  logic [CW-1:0] cnt_q, cnt_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [SOI_W-1:0] rsp_data_q, rsp_data_d, sel;
  logic idx_ok;
  assign idx_ok = {1'b0, idx_q} < NUM_W;
  assign cmd_ready_o = state_q == IDLE;
  assign force_mask_o = mask_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o = rsp_data_q;
  assign rsp_err_o = rsp_err_q;
  for (genvar i = 0; i < NUM_SOI; i++) begin : g_out
    assign soi_out_o[i*SOI_W +: SOI_W] = mask_q[i] ? val_q[i] : soi_in_i[i*SOI_W +: SOI_W];
  end
  // One-hot decode of the latched index; all zeros when the index is out of range.
  always_comb begin
    hit = '0;
    sel = '0;
    for (int i = 0; i < NUM_SOI; i++) begin
      hit[i] = 4'(i) == idx_q;
      if (hit[i]) sel = soi_out_o[i*SOI_W +: SOI_W];
    end
  end
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    idx_d = idx_q;
    data_d = data_q;
    mask_d = mask_q;
    val_d = val_q;
    cnt_d = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d = rsp_err_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        op_d = cmd_op_i;
        idx_d = cmd_idx_i;
        data_d = cmd_data_i;
        state_d = EXEC;
      end
      EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_err_d = !idx_ok;
        rsp_data_d = '0;
        state_d = RESP;
        if (idx_ok) begin
          if (op_q == 2'b00 || op_q == 2'b10) begin
            mask_d = mask_q | hit;
            for (int i = 0; i < NUM_SOI; i++) if (hit[i]) val_d[i] = data_q;
          end
          if (op_q == 2'b01) mask_d = mask_q & ~hit;
          if (op_q == 2'b11) rsp_data_d = sel;
          if (op_q == 2'b10) begin
            rsp_valid_d = 1'b0;
            cnt_d = CW'(PULSE_CYC - 1);
            state_d = PULSE;
          end
        end
      end
      PULSE: if (cnt_q == '0) begin
        mask_d = mask_q & ~hit;
        rsp_valid_d = 1'b1;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      RESP: if (rsp_ready_i) begin
        rsp_valid_d = 1'b0;
        rsp_err_d = 1'b0;
        rsp_data_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q <= '0;
      idx_q <= '0;
      data_q <= '0;
      mask_q <= '0;
      for (int i = 0; i < NUM_SOI; i++) val_q[i] <= '0;
      cnt_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      idx_q <= idx_d;
      data_q <= data_d;
      mask_q <= mask_d;
      val_q <= val_d;
      cnt_q <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
    end
  end
endmodule
